// File: rtl/press_sched_pkg.sv
// Package: press_sched_pkg
// Purpose: shared types and constants for the press scheduler.
//   sched_state_t - scheduler FSM states (IDLE, PULSE, GAP, HALT)
//   DROP_MAX      - saturation value of the merged-request counter
package press_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    HALT  = 2'd3
  } sched_state_t;

  localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/press_scheduler_arbiter.sv
// Module: rr_arbiter
// Purpose: round-robin arbiter that owns its own pointer register.
//   The search starts one past the last winner and wraps modulo N.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active high (pointer -> N-1)
//   req        in   [N] request vector
//   gnt_en     in   commit the current winner into the pointer
//   gnt_onehot out  [N] one-hot winner (zero when no request)
//   gnt_idx    out  [$clog2(N)] index of the winner
//   any        out  at least one request is set
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 gnt_en,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IdxW = $clog2(N);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;

  // Walk the N positions after the pointer; the pointer position itself
  // is visited last so the previous winner has the lowest priority.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IdxW'((int'(ptr_q) + off) % N);
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_en && any) begin
      ptr_d = gnt_idx;
    end
  end

  // Reset to N-1 so that requester 0 is the first one served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IdxW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/press_scheduler.sv
// Module: press_scheduler
// Purpose: shares one press-counter input between N requesters. Requests
//   are edge-detected and latched, granted round-robin, and turned into
//   single-cycle press pulses followed by GAP_CYCLES idle cycles. A nonzero
//   err_in from the counter parks the scheduler in HALT until clr.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active high
//   press_req    in   [N] level requests
//   err_in       in   [ERR_W] counter error, nonzero = fault
//   clr          in   clears pending and drop_count, releases HALT
//   press_out    out  one-cycle pulse to the counter press input
//   grant_id     out  requester served by the current/last pulse
//   grant_valid  out  high together with press_out
//   pending      out  [N] latched, not yet served requests
//   halted       out  high while in HALT
//   drop_count   out  [8] saturating count of merged requests
module press_scheduler
  import press_sched_pkg::*;
#(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 2,
  parameter int ERR_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         press_req,
  input  logic [ERR_W-1:0]     err_in,
  input  logic                 clr,
  output logic                 press_out,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 grant_valid,
  output logic [N-1:0]         pending,
  output logic                 halted,
  output logic [7:0]           drop_count
);

  localparam int IdxW = $clog2(N);

  sched_state_t    state_q, state_d;
  logic [3:0]      gap_q, gap_d;
  logic [N-1:0]    req_prev_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [7:0]      drop_q, drop_d;
  logic            press_q, press_d;
  logic            gvalid_q, gvalid_d;
  logic            halted_q, halted_d;
  logic [IdxW-1:0] gid_q, gid_d;

  logic [N-1:0]    rise;
  logic [N-1:0]    gnt_onehot;
  logic [N-1:0]    grant_mask;
  logic [IdxW-1:0] gnt_idx;
  logic            arb_any;
  logic            err_seen;
  logic            grant_fire;
  logic            drop_hit;

  assign rise       = press_req & ~req_prev_q;
  assign err_seen   = |err_in;
  assign grant_fire = (state_q == IDLE) && arb_any && !err_seen;
  assign grant_mask = grant_fire ? gnt_onehot : '0;

  rr_arbiter #(.N(N)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (pending_q),
    .gnt_en     (grant_fire),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (arb_any)
  );

  // A rise overrides the clear-on-grant so a request arriving exactly as
  // its previous one is served is not lost. clr overrides everything.
  always_comb begin
    pending_d = (pending_q & ~grant_mask) | rise;
    drop_hit  = |(rise & pending_q & ~grant_mask);
    drop_d    = drop_q;
    if (drop_hit && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 8'd1;
    end
    if (clr) begin
      pending_d = '0;
      drop_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Faults are honoured from every active state; PULSE still leaves after
  // one cycle, so a pulse in flight is never stretched or cut short.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (err_seen) begin
          state_d = HALT;
        end else if (grant_fire) begin
          state_d = PULSE;
        end
      end
      PULSE: begin
        gap_d = 4'(GAP_CYCLES);
        if (err_seen) begin
          state_d = HALT;
        end else if (GAP_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (err_seen) begin
          state_d = HALT;
        end else if (gap_q <= 4'd1) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      HALT: begin
        if (clr && !err_seen) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come out of flops
  // and line up with the state they describe.
  always_comb begin
    press_d  = (state_d == PULSE);
    gvalid_d = (state_d == PULSE);
    halted_d = (state_d == HALT);
    gid_d    = grant_fire ? gnt_idx : gid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_prev_q <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
      press_q    <= 1'b0;
      gvalid_q   <= 1'b0;
      halted_q   <= 1'b0;
      gid_q      <= '0;
    end else begin
      req_prev_q <= press_req;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      press_q    <= press_d;
      gvalid_q   <= gvalid_d;
      halted_q   <= halted_d;
      gid_q      <= gid_d;
    end
  end

  assign press_out   = press_q;
  assign grant_valid = gvalid_q;
  assign grant_id    = gid_q;
  assign pending     = pending_q;
  assign halted      = halted_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_press_scheduler.sv
// Testbench for press_scheduler: one instance with the default gap of two
// cycles driven through a scoreboard of expected grant ids, plus a second
// instance with no gap used for back-to-back pulses and drop saturation.
module tb_press_scheduler;

  localparam int GapMain = 2;

  logic       clk;
  logic       rst;

  logic [3:0] pressReq;
  logic [7:0] errIn;
  logic       clr;
  logic       pressOut;
  logic [1:0] grantId;
  logic       grantValid;
  logic [3:0] pending;
  logic       halted;
  logic [7:0] dropCount;

  logic [3:0] pressReqZ;
  logic [7:0] errInZ;
  logic       clrZ;
  logic       pressOutZ;
  logic [1:0] grantIdZ;
  logic       grantValidZ;
  logic [3:0] pendingZ;
  logic       haltedZ;
  logic [7:0] dropCountZ;

  int total = 0;
  int bad = 0;
  int pulseCount = 0;
  int cycleCnt = 0;
  int lastPulse = -100;
  int expQ[$];

  press_scheduler #(.N(4), .GAP_CYCLES(GapMain), .ERR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .press_req   (pressReq),
    .err_in      (errIn),
    .clr         (clr),
    .press_out   (pressOut),
    .grant_id    (grantId),
    .grant_valid (grantValid),
    .pending     (pending),
    .halted      (halted),
    .drop_count  (dropCount)
  );

  press_scheduler #(.N(4), .GAP_CYCLES(0), .ERR_W(8)) dutZ (
    .clk         (clk),
    .rst         (rst),
    .press_req   (pressReqZ),
    .err_in      (errInZ),
    .clr         (clrZ),
    .press_out   (pressOutZ),
    .grant_id    (grantIdZ),
    .grant_valid (grantValidZ),
    .pending     (pendingZ),
    .halted      (haltedZ),
    .drop_count  (dropCountZ)
  );

  // Free-running clock and an edge counter used to measure pulse spacing.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt++;

  // Every comparison goes through here so the counts stay in one place.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [7:0] err, input logic c);
    pressReq = req;
    errIn    = err;
    clr      = c;
  endtask

  // Scoreboard monitor: each pulse of the main instance must match the
  // oldest expected grant id and respect the minimum pulse spacing.
  always @(negedge clk) begin
    if (pressOut === 1'b1) begin
      pulseCount++;
      checkOutput("grant_valid_with_pulse", 32'(grantValid), 32'd1);
      checkOutput("pulse_spacing", ((cycleCnt - lastPulse) >= (2 + GapMain)) ? 32'd1 : 32'd0, 32'd1);
      lastPulse = cycleCnt;
      checkOutput("pulse_was_expected", (expQ.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (expQ.size() > 0) begin
        checkOutput("sb_grant_id", 32'(grantId), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    // Reset with every request held high.
    rst = 1'b1;
    applyStimulus(4'hF, 8'h00, 1'b0);
    pressReqZ = 4'hF;
    errInZ    = 8'h00;
    clrZ      = 1'b0;
    tick();
    tick();
    checkOutput("rst_press_out", 32'(pressOut), 32'd0);
    checkOutput("rst_grant_valid", 32'(grantValid), 32'd0);
    checkOutput("rst_grant_id", 32'(grantId), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_drop_count", 32'(dropCount), 32'd0);
    checkOutput("rst_z_press_out", 32'(pressOutZ), 32'd0);
    checkOutput("rst_z_pending", 32'(pendingZ), 32'd0);
    rst = 1'b0;
    applyStimulus(4'h0, 8'h00, 1'b0);
    pressReqZ = 4'h0;
    tick();
    tick();
    checkOutput("post_rst_no_pulse", 32'(pressOut), 32'd0);
    checkOutput("post_rst_pending", 32'(pending), 32'd0);
    checkOutput("post_rst_pulse_count", 32'(pulseCount), 32'd0);

    // Single request on requester 2: pending after one edge, pulse after two.
    applyStimulus(4'b0100, 8'h00, 1'b0);
    expQ.push_back(2);
    tick();
    checkOutput("single_pending", 32'(pending), 32'h4);
    checkOutput("single_no_early_pulse", 32'(pressOut), 32'd0);
    applyStimulus(4'b0000, 8'h00, 1'b0);
    tick();
    checkOutput("single_press_out", 32'(pressOut), 32'd1);
    checkOutput("single_grant_id", 32'(grantId), 32'd2);
    checkOutput("single_pending_cleared", 32'(pending), 32'd0);
    tick();
    checkOutput("single_pulse_one_cycle", 32'(pressOut), 32'd0);
    checkOutput("single_grant_id_holds", 32'(grantId), 32'd2);
    repeat (6) tick();
    checkOutput("single_pulse_count", 32'(pulseCount), 32'd1);

    // Round-robin from a fresh pointer: 0, 1, 3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b1011, 8'h00, 1'b0);
    expQ.push_back(0);
    expQ.push_back(1);
    expQ.push_back(3);
    tick();
    checkOutput("rr_pending", 32'(pending), 32'hB);
    applyStimulus(4'b0000, 8'h00, 1'b0);
    repeat (14) tick();
    checkOutput("rr_pulse_count", 32'(pulseCount), 32'd4);
    checkOutput("rr_pending_empty", 32'(pending), 32'd0);
    checkOutput("rr_last_grant", 32'(grantId), 32'd3);
    applyStimulus(4'b0001, 8'h00, 1'b0);
    expQ.push_back(0);
    tick();
    applyStimulus(4'b0000, 8'h00, 1'b0);
    tick();
    checkOutput("rr_wrap_press_out", 32'(pressOut), 32'd1);
    checkOutput("rr_wrap_grant_id", 32'(grantId), 32'd0);
    repeat (6) tick();

    // Merge: requester 1 waits behind 0 and rises twice more meanwhile.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b0011, 8'h00, 1'b0);
    expQ.push_back(0);
    expQ.push_back(1);
    tick();
    checkOutput("merge_pending", 32'(pending), 32'h3);
    applyStimulus(4'b0001, 8'h00, 1'b0);
    tick();
    checkOutput("merge_first_grant", 32'(grantId), 32'd0);
    checkOutput("merge_pending_after_grant", 32'(pending), 32'h2);
    applyStimulus(4'b0011, 8'h00, 1'b0);
    tick();
    checkOutput("merge_drop_one", 32'(dropCount), 32'd1);
    applyStimulus(4'b0001, 8'h00, 1'b0);
    tick();
    applyStimulus(4'b0011, 8'h00, 1'b0);
    tick();
    checkOutput("merge_drop_two", 32'(dropCount), 32'd2);
    applyStimulus(4'b0000, 8'h00, 1'b0);
    tick();
    checkOutput("merge_second_press_out", 32'(pressOut), 32'd1);
    checkOutput("merge_second_grant", 32'(grantId), 32'd1);
    repeat (6) tick();
    checkOutput("merge_pulse_count", 32'(pulseCount), 32'd7);
    checkOutput("merge_drop_final", 32'(dropCount), 32'd2);
    checkOutput("merge_pending_final", 32'(pending), 32'd0);

    // Fault raised in the PULSE cycle: pulse still one cycle, then HALT.
    applyStimulus(4'b0100, 8'h00, 1'b0);
    expQ.push_back(2);
    tick();
    applyStimulus(4'b0000, 8'h00, 1'b0);
    tick();
    checkOutput("fault_press_out", 32'(pressOut), 32'd1);
    applyStimulus(4'b0000, 8'h01, 1'b0);
    tick();
    checkOutput("fault_pulse_ended", 32'(pressOut), 32'd0);
    checkOutput("fault_halted", 32'(halted), 32'd1);
    applyStimulus(4'b1001, 8'h01, 1'b0);
    tick();
    applyStimulus(4'b0000, 8'h01, 1'b0);
    tick();
    checkOutput("halt_pending_latch", 32'(pending), 32'h9);
    applyStimulus(4'b0001, 8'h01, 1'b0);
    tick();
    applyStimulus(4'b0000, 8'h01, 1'b0);
    tick();
    checkOutput("halt_drop", 32'(dropCount), 32'd3);
    repeat (3) tick();
    checkOutput("halt_no_pulse", 32'(pulseCount), 32'd8);
    checkOutput("halt_still_halted", 32'(halted), 32'd1);
    // clr together with a fresh rise on requester 0: clr must win.
    applyStimulus(4'b0001, 8'h00, 1'b1);
    tick();
    applyStimulus(4'b0001, 8'h00, 1'b0);
    checkOutput("clr_halted", 32'(halted), 32'd0);
    checkOutput("clr_pending", 32'(pending), 32'd0);
    checkOutput("clr_drop_count", 32'(dropCount), 32'd0);
    repeat (4) tick();
    checkOutput("clr_no_pulse", 32'(pulseCount), 32'd8);
    applyStimulus(4'b0000, 8'h00, 1'b0);

    // Zero-gap instance: all four pending gives a pulse every 2 cycles.
    pressReqZ = 4'hF;
    tick();
    pressReqZ = 4'h0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput("z_press_out_high", 32'(pressOutZ), 32'd1);
      checkOutput("z_grant_id", 32'(grantIdZ), 32'(i));
      tick();
      checkOutput("z_press_out_low", 32'(pressOutZ), 32'd0);
      tick();
    end

    // Park the zero-gap instance in HALT and merge 300 rises into one.
    errInZ = 8'h01;
    tick();
    checkOutput("z_halted", 32'(haltedZ), 32'd1);
    for (int n = 1; n <= 301; n++) begin
      pressReqZ = 4'b0001;
      tick();
      pressReqZ = 4'b0000;
      tick();
      if (n == 11) begin
        checkOutput("z_drop_partial", 32'(dropCountZ), 32'd10);
      end
    end
    checkOutput("z_drop_saturated", 32'(dropCountZ), 32'd255);
    checkOutput("z_pending_held", 32'(pendingZ), 32'h1);
    checkOutput("z_no_pulse_in_halt", 32'(pressOutZ), 32'd0);

    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
